// File: rtl/sdt_data_mem.sv
// sdt_data_mem: data-side RAM serving the single-data-transfer unit.
// Byte-addressed, little-endian, word-organised storage with registered
// word and byte read ports, word and byte write ports, write-first
// bypass and a sticky out-of-range abort flag.
// Optional build macro: SDT_DATA_MEM_ROTATE_EN -- when defined, unaligned
// word reads return the aligned word rotated right by 8*addr[1:0].
module sdt_data_mem #(
   parameter int unsigned DEPTH_WORDS = 1024,          // power of two, >= 2
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000  // aligned to DEPTH_WORDS*4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_read_word_en,
   input  logic [31:0] data_read_word_address,
   output logic [31:0] data_read_word_data,
   input  logic        data_read_byte_en,
   input  logic [31:0] data_read_byte_address,
   output logic [7:0]  data_read_byte_data,
   input  logic        data_write_word_en,
   input  logic [31:0] data_write_word_address,
   input  logic [31:0] data_write_word_data,
   input  logic        data_write_byte_en,
   input  logic [31:0] data_write_byte_address,
   input  logic [7:0]  data_write_byte_data,
   output logic        data_abort,
   output logic [31:0] abort_address
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

   // Storage
   logic [31:0] mem_q [DEPTH_WORDS];

   // Offsets from the window base; range check is a single unsigned compare
   logic [31:0] rw_off, rb_off, ww_off, wb_off;
   logic        rw_in, rb_in, ww_in, wb_in;
   logic [IDX_W-1:0] rw_idx, rb_idx, ww_idx, wb_idx;
   logic [1:0]  rb_lane, wb_lane;
   logic        ww_ok, wb_ok;

   assign rw_off = data_read_word_address  - BASE_ADDR;
   assign rb_off = data_read_byte_address  - BASE_ADDR;
   assign ww_off = data_write_word_address - BASE_ADDR;
   assign wb_off = data_write_byte_address - BASE_ADDR;

   assign rw_in = rw_off < SPAN;
   assign rb_in = rb_off < SPAN;
   assign ww_in = ww_off < SPAN;
   assign wb_in = wb_off < SPAN;

   assign rw_idx = rw_off[IDX_W+1:2];
   assign rb_idx = rb_off[IDX_W+1:2];
   assign ww_idx = ww_off[IDX_W+1:2];
   assign wb_idx = wb_off[IDX_W+1:2];

   // Base is aligned, so offset low bits equal address low bits
   assign rb_lane = rb_off[1:0];
   assign wb_lane = wb_off[1:0];

   assign ww_ok = data_write_word_en & ww_in;
   assign wb_ok = data_write_byte_en & wb_in;

   // Word writes are force-aligned; these offset bits are intentionally dropped
   logic unused_bits;
   assign unused_bits = ^{ww_off[1:0], rw_off[1:0]};

   // Array update: word write first, byte write then overrides its lane
   // NOTE: the array is deliberately left out of reset -- clearing it would
   // force flops instead of RAM; a write on an edge with rst high is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (ww_ok) mem_q[ww_idx] <= data_write_word_data;
         if (wb_ok) mem_q[wb_idx][{wb_lane, 3'b000} +: 8] <= data_write_byte_data;
      end
   end

   // Write-first bypass: merge same-cycle writes into each read's word
   logic [31:0] rw_merged, rb_merged;
   // NOTE: every variable in always_comb gets a default first so no latch forms.
   always_comb begin
      rw_merged = mem_q[rw_idx];
      if (ww_ok && (ww_idx == rw_idx)) rw_merged = data_write_word_data;
      if (wb_ok && (wb_idx == rw_idx)) rw_merged[{wb_lane, 3'b000} +: 8] = data_write_byte_data;

      rb_merged = mem_q[rb_idx];
      if (ww_ok && (ww_idx == rb_idx)) rb_merged = data_write_word_data;
      if (wb_ok && (wb_idx == rb_idx)) rb_merged[{wb_lane, 3'b000} +: 8] = data_write_byte_data;
   end

   // Word read formatting (optional ARM7 LDR rotation after bypass)
   logic [31:0] rw_fmt;
`ifdef SDT_DATA_MEM_ROTATE_EN
   always_comb begin
      unique case (data_read_word_address[1:0])
         2'd0:    rw_fmt = rw_merged;
         2'd1:    rw_fmt = {rw_merged[7:0],  rw_merged[31:8]};
         2'd2:    rw_fmt = {rw_merged[15:0], rw_merged[31:16]};
         default: rw_fmt = {rw_merged[23:0], rw_merged[31:24]};
      endcase
   end
`else
   assign rw_fmt = rw_merged;
`endif

   // Next-state for read registers: load on strobe, zero if out of range
   logic [31:0] rd_word_q, rd_word_d;
   logic [7:0]  rd_byte_q, rd_byte_d;
   always_comb begin
      rd_word_d = rd_word_q;
      rd_byte_d = rd_byte_q;
      if (data_read_word_en) rd_word_d = rw_in ? rw_fmt : 32'h0;
      if (data_read_byte_en) rd_byte_d = rb_in ? rb_merged[{rb_lane, 3'b000} +: 8] : 8'h0;
   end

   // Next-state for abort flag and first-abort address capture
   logic        abort_q, abort_d;
   logic [31:0] abort_addr_q, abort_addr_d;
   logic        ww_bad, wb_bad, rw_bad, rb_bad;
   assign ww_bad = data_write_word_en & ~ww_in;
   assign wb_bad = data_write_byte_en & ~wb_in;
   assign rw_bad = data_read_word_en  & ~rw_in;
   assign rb_bad = data_read_byte_en  & ~rb_in;

   always_comb begin
      abort_d      = abort_q;
      abort_addr_d = abort_addr_q;
      if (!abort_q && (ww_bad || wb_bad || rw_bad || rb_bad)) begin
         abort_d = 1'b1;
         if (ww_bad)      abort_addr_d = data_write_word_address;
         else if (wb_bad) abort_addr_d = data_write_byte_address;
         else if (rw_bad) abort_addr_d = data_read_word_address;
         else             abort_addr_d = data_read_byte_address;
      end
   end

   // Registered outputs and abort state with asynchronous reset
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_word_q    <= 32'h0;
         rd_byte_q    <= 8'h0;
         abort_q      <= 1'b0;
         abort_addr_q <= 32'h0;
      end else begin
         rd_word_q    <= rd_word_d;
         rd_byte_q    <= rd_byte_d;
         abort_q      <= abort_d;
         abort_addr_q <= abort_addr_d;
      end
   end

   assign data_read_word_data = rd_word_q;
   assign data_read_byte_data = rd_byte_q;
   assign data_abort          = abort_q;
   assign abort_address       = abort_addr_q;

endmodule

// File: tb/tb_sdt_data_mem.sv
// tb_sdt_data_mem: directed self-checking bench for sdt_data_mem
// (DEPTH_WORDS=1024, BASE_ADDR=0). Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
module tb_sdt_data_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        rw_en, rb_en, ww_en, wb_en;
   logic [31:0] rw_addr, rb_addr, ww_addr, wb_addr, ww_data;
   logic [7:0]  wb_data;
   logic [31:0] rw_out;
   logic [7:0]  rb_out;
   logic        abort;
   logic [31:0] abort_addr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sdt_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .data_read_word_en       (rw_en),
      .data_read_word_address  (rw_addr),
      .data_read_word_data     (rw_out),
      .data_read_byte_en       (rb_en),
      .data_read_byte_address  (rb_addr),
      .data_read_byte_data     (rb_out),
      .data_write_word_en      (ww_en),
      .data_write_word_address (ww_addr),
      .data_write_word_data    (ww_data),
      .data_write_byte_en      (wb_en),
      .data_write_byte_address (wb_addr),
      .data_write_byte_data    (wb_data),
      .data_abort              (abort),
      .abort_address           (abort_addr)
   );

   task automatic idle();
      rw_en = 0; rb_en = 0; ww_en = 0; wb_en = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rw_addr = 0; rb_addr = 0; ww_addr = 0; wb_addr = 0; ww_data = 0; wb_data = 0;
      rst = 1;
      #12;
      total++; if (rw_out !== 32'h0) begin bad++; $display("FAIL reset_word got=%h exp=%h", rw_out, 32'h0); end
      total++; if (rb_out !== 8'h0) begin bad++; $display("FAIL reset_byte got=%h exp=%h", rb_out, 8'h0); end
      total++; if (abort !== 1'b0) begin bad++; $display("FAIL reset_abort got=%b exp=0", abort); end
      total++; if (abort_addr !== 32'h0) begin bad++; $display("FAIL reset_abort_addr got=%h exp=0", abort_addr); end
      @(negedge clk);
      rst = 0;
      tick();
   endtask

   task automatic test_word_rw();
      ww_en = 1; ww_addr = 32'h10; ww_data = 32'hDEADBEEF;
      tick(); idle();
      rw_en = 1; rw_addr = 32'h10;
      tick(); idle();
      total++; if (rw_out !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rw got=%h exp=DEADBEEF", rw_out); end
      rw_addr = 32'h20;  // address changes with en low must not matter
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (rw_out !== 32'hDEADBEEF) begin bad++; $display("FAIL word_hold%0d got=%h exp=DEADBEEF", i, rw_out); end
      end
   endtask

   task automatic test_byte_lanes();
      ww_en = 1; ww_addr = 32'h20; ww_data = 32'h0;
      tick(); idle();
      wb_en = 1; wb_addr = 32'h20; wb_data = 8'hAA;
      tick();
      wb_addr = 32'h23; wb_data = 8'h55;
      tick(); idle();
      rw_en = 1; rw_addr = 32'h20; rb_en = 1; rb_addr = 32'h23;
      tick(); idle();
      total++; if (rw_out !== 32'h550000AA) begin bad++; $display("FAIL byte_word got=%h exp=550000AA", rw_out); end
      total++; if (rb_out !== 8'h55) begin bad++; $display("FAIL byte_lane3 got=%h exp=55", rb_out); end
      rb_en = 1; rb_addr = 32'h20;
      tick(); idle();
      total++; if (rb_out !== 8'hAA) begin bad++; $display("FAIL byte_lane0 got=%h exp=AA", rb_out); end
      total++; if (rw_out !== 32'h550000AA) begin bad++; $display("FAIL byte_word_hold got=%h exp=550000AA", rw_out); end
   endtask

   task automatic test_same_cycle();
      ww_en = 1; ww_addr = 32'h40; ww_data = 32'h12345678;
      wb_en = 1; wb_addr = 32'h41; wb_data = 8'h99;
      rw_en = 1; rw_addr = 32'h40;
      rb_en = 1; rb_addr = 32'h41;
      tick(); idle();
      total++; if (rw_out !== 32'h12349978) begin bad++; $display("FAIL bypass_word got=%h exp=12349978", rw_out); end
      total++; if (rb_out !== 8'h99) begin bad++; $display("FAIL bypass_byte got=%h exp=99", rb_out); end
      rw_en = 1; rw_addr = 32'h40;
      tick(); idle();
      total++; if (rw_out !== 32'h12349978) begin bad++; $display("FAIL stored_merge got=%h exp=12349978", rw_out); end
   endtask

   task automatic test_unaligned();
      logic [31:0] exp_w;
`ifdef SDT_DATA_MEM_ROTATE_EN
      exp_w = 32'h22114433;
`else
      exp_w = 32'h44332211;
`endif
      ww_en = 1; ww_addr = 32'h100; ww_data = 32'h44332211;
      tick(); idle();
      rw_en = 1; rw_addr = 32'h102; rb_en = 1; rb_addr = 32'h101;
      tick(); idle();
      total++; if (rw_out !== exp_w) begin bad++; $display("FAIL unaligned_word got=%h exp=%h", rw_out, exp_w); end
      total++; if (rb_out !== 8'h22) begin bad++; $display("FAIL unaligned_byte got=%h exp=22", rb_out); end
   endtask

   task automatic test_top_boundary();
      ww_en = 1; ww_addr = 32'hFFC; ww_data = 32'hA5A5_5A5A;
      tick(); idle();
      rw_en = 1; rw_addr = 32'hFFC; rb_en = 1; rb_addr = 32'hFFF;
      tick(); idle();
      total++; if (rw_out !== 32'hA5A55A5A) begin bad++; $display("FAIL top_word got=%h exp=A5A55A5A", rw_out); end
      total++; if (rb_out !== 8'hA5) begin bad++; $display("FAIL top_byte got=%h exp=A5", rb_out); end
      total++; if (abort !== 1'b0) begin bad++; $display("FAIL top_no_abort got=%b exp=0", abort); end
   endtask

   task automatic test_abort();
      ww_en = 1; ww_addr = 32'h0; ww_data = 32'h0BADF00D;
      tick(); idle();
      ww_en = 1; ww_addr = 32'h1000; ww_data = 32'hCAFEF00D;
      tick(); idle();
      total++; if (abort !== 1'b1) begin bad++; $display("FAIL abort_set got=%b exp=1", abort); end
      total++; if (abort_addr !== 32'h1000) begin bad++; $display("FAIL abort_addr got=%h exp=00001000", abort_addr); end
      rw_en = 1; rw_addr = 32'h0;
      tick(); idle();
      total++; if (rw_out !== 32'h0BADF00D) begin bad++; $display("FAIL abort_suppressed got=%h exp=0BADF00D", rw_out); end
      rw_en = 1; rw_addr = 32'h2000; rb_en = 1; rb_addr = 32'h3001;
      tick(); idle();
      total++; if (rw_out !== 32'h0) begin bad++; $display("FAIL abort_read_zero got=%h exp=0", rw_out); end
      total++; if (rb_out !== 8'h0) begin bad++; $display("FAIL abort_byte_zero got=%h exp=0", rb_out); end
      total++; if (abort_addr !== 32'h1000) begin bad++; $display("FAIL abort_addr_sticky got=%h exp=00001000", abort_addr); end
      total++; if (abort !== 1'b1) begin bad++; $display("FAIL abort_sticky got=%b exp=1", abort); end
   endtask

   task automatic test_async_reset();
      rw_en = 1; rw_addr = 32'h10;
      tick(); idle();
      total++; if (rw_out !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_reset got=%h exp=DEADBEEF", rw_out); end
      #2 rst = 1;
      #1;
      total++; if (rw_out !== 32'h0) begin bad++; $display("FAIL async_word got=%h exp=0", rw_out); end
      total++; if (abort !== 1'b0) begin bad++; $display("FAIL async_abort got=%b exp=0", abort); end
      total++; if (abort_addr !== 32'h0) begin bad++; $display("FAIL async_abort_addr got=%h exp=0", abort_addr); end
      // write presented on an edge with reset high must be dropped
      ww_en = 1; ww_addr = 32'h10; ww_data = 32'h11111111;
      tick(); idle();
      rst = 0;
      tick();
      rw_en = 1; rw_addr = 32'h10;
      tick(); idle();
      total++; if (rw_out !== 32'hDEADBEEF) begin bad++; $display("FAIL post_reset got=%h exp=DEADBEEF", rw_out); end
   endtask

   task automatic test_abort_priority();
      wb_en = 1; wb_addr = 32'h3000; wb_data = 8'h77;
      rw_en = 1; rw_addr = 32'h4000;
      rb_en = 1; rb_addr = 32'h5000;
      tick(); idle();
      total++; if (abort !== 1'b1) begin bad++; $display("FAIL prio_abort got=%b exp=1", abort); end
      total++; if (abort_addr !== 32'h3000) begin bad++; $display("FAIL prio_addr got=%h exp=00003000", abort_addr); end
      rw_en = 1; rw_addr = 32'h6000;
      tick(); idle();
      total++; if (abort_addr !== 32'h3000) begin bad++; $display("FAIL prio_addr_hold got=%h exp=00003000", abort_addr); end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_lanes();
      test_same_cycle();
      test_unaligned();
      test_top_boundary();
      test_abort();
      test_async_reset();
      test_abort_priority();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdt_data_mem.md
Name: sdt_data_mem

Overview:
- Data-side memory directly downstream of the single-data-transfer (LDR/STR/LDRB/STRB) unit.
- Serves its four strobe ports: word read, byte read, word write and byte write.
- Byte-addressed, little-endian, word-organised synchronous RAM.
- Registered read data is held stable between reads, so the SDT can sample it two cycles after strobing.
- Detects out-of-range accesses and reports them on a sticky abort flag.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored; must be a power of two.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
data_read_word_en  input  1  word read strobe
data_read_word_address  input  32  byte address of word read
data_read_word_data  output  32  registered word read result
data_read_byte_en  input  1  byte read strobe
data_read_byte_address  input  32  byte address of byte read
data_read_byte_data  output  8  registered byte read result
data_write_word_en  input  1  word write strobe
data_write_word_address  input  32  byte address of word write
data_write_word_data  input  32  word write data
data_write_byte_en  input  1  byte write strobe
data_write_byte_address  input  32  byte address of byte write
data_write_byte_data  input  8  byte write data
data_abort  output  1  sticky: an out-of-range access occurred
abort_address  output  32  address of the first aborting access

Behaviour:
- Reset (async, rst=1): data_read_word_data=0, data_read_byte_data=0, data_abort=0, abort_address=0. Array contents are not cleared.
- In range: (addr - BASE_ADDR) < DEPTH_WORDS*4, computed unsigned, 32-bit.
- Word index = (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0], lane 0 = bits 7:0.
- Word write, in range, at edge with en=1: stores the full word at the word index. addr[1:0] is ignored, so the write is force-aligned.
- Byte write, in range: updates only the selected lane; the other three lanes are unchanged.
- Word write and byte write in the same cycle to the same word:
  - Both are applied.
  - The byte write overrides its lane of the word data.
- Read latency is 1 cycle:
  - A strobe at edge N updates the corresponding output register at edge N.
  - The value is visible after edge N.
  - The output holds until the next strobe of that read port, or until reset. It holds regardless of en falling.
- Word read with unaligned addr[1:0]: returns the aligned word. See the optional feature for rotation.
- Byte read: returns the selected lane.
- Read and write to the same word in the same cycle are write-first: the read returns the post-write merged value. This needs explicit bypass logic, not array timing.
- Word read and byte read in the same cycle are independent; both are serviced.
- Out-of-range access on any strobe:
  - Write: suppressed, array unchanged.
  - Read: that output register loads 0.
  - data_abort sets to 1 and stays set until rst.
  - abort_address captures the address only on the 0->1 transition of data_abort.
  - If several ports abort in the same cycle, capture priority is word write > byte write > word read > byte read.
- Strobes held high for multiple cycles repeat the access every cycle; this is idempotent for the SDT's one-cycle pulses.
- Reset asserted mid-operation: output registers and abort state clear immediately. Any write on the edge coincident with rst=1 is dropped.

Optional Feature:
- Macro: SDT_DATA_MEM_ROTATE_EN.
- Defined:
  - Unaligned word reads return the aligned word rotated right by 8*addr[1:0] (ARM7 LDR semantics).
  - Example: word 0x44332211 at 0x100, read at 0x101 -> 0x11443322.
  - Write-first bypass applies before rotation.
- Undefined: the aligned word is returned unrotated (0x44332211 in the example). No rotate logic is synthesised.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x10 next cycle -> data_read_word_data=0xDEADBEEF one cycle after strobe; value held 5 cycles with en=0.
- Byte writes 0xAA@0x20 and 0x55@0x23 over a prior word 0x00000000 -> word read @0x20 = 0x550000AA; byte read @0x23 = 0x55.
- Same cycle: word write 0x12345678 @0x40, byte write 0x99 @0x41 and word read @0x40 -> stored and read value 0x12349978 (write-first, byte override).
- Word 0x44332211 @0x100, word read @0x102 -> 0x22114433 with SDT_DATA_MEM_ROTATE_EN; 0x44332211 without it.
- DEPTH_WORDS=1024, BASE_ADDR=0:
  - Word write @0x1000 -> array unchanged, data_abort=1, abort_address=0x1000.
  - A later read @0x2000 -> output 0, abort_address stays 0x1000.
- Assert rst asynchronously between strobe and sample -> outputs 0 immediately, data_abort=0; previously written 0xDEADBEEF @0x10 still reads back after rst release.
